multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/alu_decode.sv | 40 ++++
 rtl/multicycle_controller.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, function
// codes, ALU operations and controller state names.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Coarse ALU request from the FSM; only ALUOP_FUNCT consults the funct field.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQ    = 4'd8,
        S_BNE    = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

endpackage

// File: rtl/alu_decode.sv
// ALU control decode: turns the FSM's coarse ALU request plus the R-type funct
// field into a 3-bit ALU operation, and flags funct codes outside the supported set.
module alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    input  aluop_t     aluop,
    output logic [2:0] alucontrol,
    output logic       funct_illegal
);

    logic [2:0] funct_code;

    // funct_illegal is independent of aluop so the write-back state can use it too.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path that skips an assignment would infer a latch.
        funct_code    = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FUNCT_ADD: funct_code = ALU_ADD;
            FUNCT_SUB: funct_code = ALU_SUB;
            FUNCT_AND: funct_code = ALU_AND;
            FUNCT_OR:  funct_code = ALU_OR;
            FUNCT_SLT: funct_code = ALU_SLT;
            default:   funct_illegal = 1'b1;
        endcase
    end

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD:   alucontrol = ALU_ADD;
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: alucontrol = funct_code;
            ALUOP_OR:    alucontrol = ALU_OR;
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for a multicycle MIPS subset (lw, sw, R-type, beq,
// bne, addi, ori, j) with optional memory wait states and a retired-instruction counter.
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int ACW      = 3,
    parameter int MEM_WAIT = 0,
    parameter int EN_BNE   = 1,
    parameter int CNTW     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      op,
    input  logic [5:0]      funct,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pcen,
    output logic            memwrite,
    output logic            irwrite,
    output logic            regwrite,
    output logic            iord,
    output logic            memtoreg,
    output logic            regdst,
    output logic            alusrca,
    output logic            extop,
    output logic [1:0]      alusrcb,
    output logic [1:0]      pcsrc,
    output logic [ACW-1:0]  alucontrol,
    output logic            instr_done,
    output logic            illegal_op,
    output logic [CNTW-1:0] instret
);

    state_t     state, next_state;
    aluop_t     aluop;
    logic [2:0] alu_code;
    logic       funct_illegal;
    logic       mem_ok;
    logic       pcwrite;
    logic       branch_eq;
    logic       branch_ne;

    // Without wait states the memory is treated as completing every access at once.
    assign mem_ok = (MEM_WAIT == 0) || mem_ready;

    alu_decode u_alu_decode (
        .funct         (funct),
        .aluop         (aluop),
        .alucontrol    (alu_code),
        .funct_illegal (funct_illegal)
    );

    assign alucontrol = ACW'(alu_code);

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        aluop      = ALUOP_ADD;
        pcwrite    = 1'b0;
        branch_eq  = 1'b0;
        branch_ne  = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        extop      = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (state)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ok;
                pcwrite = mem_ok;
                if (mem_ok) next_state = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW:     next_state = S_MEMADR;
                    OP_RTYPE:         next_state = S_RTEX;
                    OP_BEQ:           next_state = S_BEQ;
                    OP_ADDI, OP_ORI:  next_state = S_IMMEX;
                    OP_J:             next_state = S_JUMP;
                    OP_BNE: begin
                        if (EN_BNE != 0) begin
                            next_state = S_BNE;
                        end else begin
                            next_state = S_FETCH;
                            illegal_op = 1'b1;
                        end
                    end
                    default: begin
                        next_state = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ok) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite   = mem_ok;
                instr_done = mem_ok;
                if (mem_ok) next_state = S_FETCH;
            end
            S_RTEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                illegal_op = funct_illegal;
                next_state = S_RTWB;
            end
            S_RTWB: begin
                // An unsupported funct still walks through write-back but neither writes nor retires.
                regdst     = 1'b1;
                regwrite   = ~funct_illegal;
                instr_done = ~funct_illegal;
                next_state = S_FETCH;
            end
            S_BEQ, S_BNE: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = 2'b01;
                branch_eq  = (state == S_BEQ);
                branch_ne  = (state == S_BNE);
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == OP_ORI) begin
                    aluop = ALUOP_OR;
                    extop = 1'b1;
                end
                next_state = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase

        pcen = pcwrite | (branch_eq & zero) | (branch_ne & ~zero);

        // Enables and pulses stay quiet for the whole reset interval, not just after the edge.
        if (reset) begin
            pcen       = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            memwrite   = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           instret <= '0;
        else if (instr_done) instret <= instret + CNTW'(1);
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-cycle control-vector table
// plus hand-written sequences for wait states, mid-instruction reset and counter wrap.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b100011;
    logic [5:0] funct = 6'b100000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic        pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca, extop;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic        instr_done, illegal_op;
    logic [31:0] instret;

    logic        d1_pcen, d1_memwrite, d1_irwrite, d1_regwrite, d1_iord, d1_memtoreg;
    logic        d1_regdst, d1_alusrca, d1_extop;
    logic [1:0]  d1_alusrcb, d1_pcsrc;
    logic [2:0]  d1_alucontrol;
    logic        d1_instr_done, d1_illegal_op;
    logic [3:0]  d1_instret;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .iord(iord),
        .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca), .extop(extop),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .instr_done(instr_done), .illegal_op(illegal_op), .instret(instret)
    );

    multicycle_controller #(.MEM_WAIT(1), .CNTW(4)) dut_wait (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(d1_pcen), .memwrite(d1_memwrite), .irwrite(d1_irwrite), .regwrite(d1_regwrite),
        .iord(d1_iord), .memtoreg(d1_memtoreg), .regdst(d1_regdst), .alusrca(d1_alusrca),
        .extop(d1_extop), .alusrcb(d1_alusrcb), .pcsrc(d1_pcsrc), .alucontrol(d1_alucontrol),
        .instr_done(d1_instr_done), .illegal_op(d1_illegal_op), .instret(d1_instret)
    );

    // Vector layout: {pcen,memwrite,irwrite,regwrite,iord,memtoreg,regdst,alusrca,extop}_alusrcb_pcsrc_alucontrol_{done,illegal}
    logic [17:0] act0, act1;
    assign act0 = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca, extop,
                   alusrcb, pcsrc, alucontrol, instr_done, illegal_op};
    assign act1 = {d1_pcen, d1_memwrite, d1_irwrite, d1_regwrite, d1_iord, d1_memtoreg, d1_regdst,
                   d1_alusrca, d1_extop, d1_alusrcb, d1_pcsrc, d1_alucontrol, d1_instr_done, d1_illegal_op};

    localparam logic [17:0] V_F        = 18'b101000000_01_00_010_00;
    localparam logic [17:0] V_D        = 18'b000000000_11_00_010_00;
    localparam logic [17:0] V_D_ILL    = 18'b000000000_11_00_010_01;
    localparam logic [17:0] V_MA       = 18'b000000010_10_00_010_00;
    localparam logic [17:0] V_MR       = 18'b000010000_00_00_010_00;
    localparam logic [17:0] V_MWB      = 18'b000101000_00_00_010_10;
    localparam logic [17:0] V_MWR      = 18'b010010000_00_00_010_10;
    localparam logic [17:0] V_RT_ADD   = 18'b000000010_00_00_010_00;
    localparam logic [17:0] V_RT_SUB   = 18'b000000010_00_00_110_00;
    localparam logic [17:0] V_RT_OR    = 18'b000000010_00_00_001_00;
    localparam logic [17:0] V_RT_SLT   = 18'b000000010_00_00_111_00;
    localparam logic [17:0] V_RT_BAD   = 18'b000000010_00_00_010_01;
    localparam logic [17:0] V_RTWB     = 18'b000100100_00_00_010_10;
    localparam logic [17:0] V_RTWB_BAD = 18'b000000100_00_00_010_00;
    localparam logic [17:0] V_BR_TAKEN = 18'b100000010_00_01_110_10;
    localparam logic [17:0] V_BR_NOT   = 18'b000000010_00_01_110_10;
    localparam logic [17:0] V_IMM_ADDI = 18'b000000010_10_00_010_00;
    localparam logic [17:0] V_IMM_ORI  = 18'b000000011_10_00_001_00;
    localparam logic [17:0] V_IMMWB    = 18'b000100000_00_00_010_10;
    localparam logic [17:0] V_J        = 18'b100000000_00_10_010_10;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [17:0] exp;
        int          exp_instret;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic [17:0] e, input int n, input string nm);
        vec_t r;
        r.op = o; r.funct = f; r.zero = z; r.exp = e; r.exp_instret = n; r.name = nm;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Expected control vectors cycle by cycle; instret is the value seen during the cycle.
        v(6'b100011, 6'b000000, 1'b0, V_F,   0, "lw.fetch");
        v(6'b100011, 6'b000000, 1'b0, V_D,   0, "lw.decode");
        v(6'b100011, 6'b000000, 1'b0, V_MA,  0, "lw.memadr");
        v(6'b100011, 6'b000000, 1'b0, V_MR,  0, "lw.memrd");
        v(6'b100011, 6'b000000, 1'b0, V_MWB, 0, "lw.memwb");
        v(6'b101011, 6'b000000, 1'b0, V_F,   1, "sw.fetch");
        v(6'b101011, 6'b000000, 1'b0, V_D,   1, "sw.decode");
        v(6'b101011, 6'b000000, 1'b0, V_MA,  1, "sw.memadr");
        v(6'b101011, 6'b000000, 1'b0, V_MWR, 1, "sw.memwr");
        v(6'b000000, 6'b100000, 1'b0, V_F,      2, "add.fetch");
        v(6'b000000, 6'b100000, 1'b0, V_D,      2, "add.decode");
        v(6'b000000, 6'b100000, 1'b0, V_RT_ADD, 2, "add.rtex");
        v(6'b000000, 6'b100000, 1'b0, V_RTWB,   2, "add.rtwb");
        v(6'b000000, 6'b101010, 1'b0, V_F,      3, "slt.fetch");
        v(6'b000000, 6'b101010, 1'b0, V_D,      3, "slt.decode");
        v(6'b000000, 6'b101010, 1'b0, V_RT_SLT, 3, "slt.rtex");
        v(6'b000000, 6'b101010, 1'b0, V_RTWB,   3, "slt.rtwb");
        v(6'b000000, 6'b100010, 1'b0, V_F,      4, "sub.fetch");
        v(6'b000000, 6'b100010, 1'b0, V_D,      4, "sub.decode");
        v(6'b000000, 6'b100010, 1'b0, V_RT_SUB, 4, "sub.rtex");
        v(6'b000000, 6'b100010, 1'b0, V_RTWB,   4, "sub.rtwb");
        v(6'b000000, 6'b100101, 1'b0, V_F,      5, "or.fetch");
        v(6'b000000, 6'b100101, 1'b0, V_D,      5, "or.decode");
        v(6'b000000, 6'b100101, 1'b0, V_RT_OR,  5, "or.rtex");
        v(6'b000000, 6'b100101, 1'b0, V_RTWB,   5, "or.rtwb");
        v(6'b000000, 6'b000000, 1'b0, V_F,          6, "badfn.fetch");
        v(6'b000000, 6'b000000, 1'b0, V_D,          6, "badfn.decode");
        v(6'b000000, 6'b000000, 1'b0, V_RT_BAD,     6, "badfn.rtex");
        v(6'b000000, 6'b000000, 1'b0, V_RTWB_BAD,   6, "badfn.rtwb");
        v(6'b000100, 6'b000000, 1'b1, V_F,          6, "beqz1.fetch");
        v(6'b000100, 6'b000000, 1'b1, V_D,          6, "beqz1.decode");
        v(6'b000100, 6'b000000, 1'b1, V_BR_TAKEN,   6, "beqz1.beq");
        v(6'b000101, 6'b000000, 1'b1, V_F,          7, "bnez1.fetch");
        v(6'b000101, 6'b000000, 1'b1, V_D,          7, "bnez1.decode");
        v(6'b000101, 6'b000000, 1'b1, V_BR_NOT,     7, "bnez1.bne");
        v(6'b000100, 6'b000000, 1'b0, V_F,          8, "beqz0.fetch");
        v(6'b000100, 6'b000000, 1'b0, V_D,          8, "beqz0.decode");
        v(6'b000100, 6'b000000, 1'b0, V_BR_NOT,     8, "beqz0.beq");
        v(6'b000101, 6'b000000, 1'b0, V_F,          9, "bnez0.fetch");
        v(6'b000101, 6'b000000, 1'b0, V_D,          9, "bnez0.decode");
        v(6'b000101, 6'b000000, 1'b0, V_BR_TAKEN,   9, "bnez0.bne");
        v(6'b001000, 6'b000000, 1'b0, V_F,          10, "addi.fetch");
        v(6'b001000, 6'b000000, 1'b0, V_D,          10, "addi.decode");
        v(6'b001000, 6'b000000, 1'b0, V_IMM_ADDI,   10, "addi.immex");
        v(6'b001000, 6'b000000, 1'b0, V_IMMWB,      10, "addi.immwb");
        v(6'b001101, 6'b000000, 1'b0, V_F,          11, "ori.fetch");
        v(6'b001101, 6'b000000, 1'b0, V_D,          11, "ori.decode");
        v(6'b001101, 6'b000000, 1'b0, V_IMM_ORI,    11, "ori.immex");
        v(6'b001101, 6'b000000, 1'b0, V_IMMWB,      11, "ori.immwb");
        v(6'b000010, 6'b000000, 1'b0, V_F,          12, "j.fetch");
        v(6'b000010, 6'b000000, 1'b0, V_D,          12, "j.decode");
        v(6'b000010, 6'b000000, 1'b0, V_J,          12, "j.jump");
        v(6'b111111, 6'b000000, 1'b0, V_F,          13, "illop.fetch");
        v(6'b111111, 6'b000000, 1'b0, V_D_ILL,      13, "illop.decode");
        v(6'b100011, 6'b000000, 1'b0, V_F,          13, "end.fetch");

        // Outputs while reset is held: FETCH would otherwise raise irwrite/pcen.
        @(negedge clk);
        check("rst.pcen", 32'(pcen), 32'd0);
        check("rst.irwrite", 32'(irwrite), 32'd0);
        check("rst.regwrite", 32'(regwrite), 32'd0);
        check("rst.memwrite", 32'(memwrite), 32'd0);
        check("rst.instr_done", 32'(instr_done), 32'd0);
        check("rst.instret", instret, 32'd0);
        check("rst.wait.irwrite", 32'(d1_irwrite), 32'd0);
        do_reset();

        foreach (vecs[i]) begin
            op    = vecs[i].op;
            funct = vecs[i].funct;
            zero  = vecs[i].zero;
            @(negedge clk);
            check({vecs[i].name, ".ctrl"}, 32'(act0), 32'(vecs[i].exp));
            check({vecs[i].name, ".wait_ctrl"}, 32'(act1), 32'(vecs[i].exp));
            check({vecs[i].name, ".instret"}, instret, 32'(vecs[i].exp_instret));
            tick();
        end

        // Wait states in FETCH: three cycles held, then one cycle of irwrite/pcen.
        zero = 1'b0;
        op = 6'b100011;
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wait.hold.irwrite", 32'(d1_irwrite), 32'd0);
            check("wait.hold.pcen", 32'(d1_pcen), 32'd0);
            check("wait.hold.alusrcb", 32'(d1_alusrcb), 32'd1);
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("wait.ready.irwrite", 32'(d1_irwrite), 32'd1);
        check("wait.ready.pcen", 32'(d1_pcen), 32'd1);
        tick();
        @(negedge clk);
        check("wait.decode.alusrcb", 32'(d1_alusrcb), 32'd3);
        check("wait.decode.irwrite", 32'(d1_irwrite), 32'd0);
        tick();

        // Reset in the middle of a store: everything drops at once, count clears.
        do_reset();
        op = 6'b000010;
        repeat (3) tick();
        op = 6'b101011;
        repeat (3) tick();
        @(negedge clk);
        check("rstmid.pre.memwrite", 32'(memwrite), 32'd1);
        check("rstmid.pre.instret", instret, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid.memwrite", 32'(memwrite), 32'd0);
        check("rstmid.instret", instret, 32'd0);
        check("rstmid.instr_done", 32'(instr_done), 32'd0);
        check("rstmid.irwrite", 32'(irwrite), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstmid.fetch.irwrite", 32'(irwrite), 32'd1);
        check("rstmid.fetch.alusrcb", 32'(alusrcb), 32'd1);
        tick();

        // Sixteen addi: the 4-bit counter wraps while the 32-bit one reaches 16.
        do_reset();
        op = 6'b001000;
        for (int i = 0; i < 16; i++) begin
            repeat (4) tick();
            if (i == 14) check("wrap.instret15", 32'(d1_instret), 32'd15);
        end
        @(negedge clk);
        check("wrap.instret_cntw4", 32'(d1_instret), 32'd0);
        check("wrap.instret_cntw32", instret, 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
